// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing generator driven by a one-in-N pixel
// enable on the master clock. Produces pixel/line counts, sync pulses, the
// active-video flag and line/frame start strobes, all registered and aligned
// with the counts they describe.
// Optional feature: define VGA_FRAME_COUNTER_EN to add the 16-bit frame_cnt
// output counting completed frames.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  // Totals must fit the 10-bit counters (H_TOTAL, V_TOTAL <= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds carry an extra bit so an end value of 1024 stays exact.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_LO  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_HI  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_LO  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_HI  = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Unsigned half-open window test: lo <= c < hi.
  function automatic logic in_window(input logic [9:0]  c,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, c} >= lo) && ({1'b0, c} < hi);
  endfunction

  // Sync level for a given count: asserted level inside the window.
  function automatic logic sync_level(input logic [9:0]  c,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi,
                                      input logic        pol);
    return in_window(c, lo, hi) ? pol : ~pol;
  endfunction

  logic [9:0] hcount_p0;
  logic [9:0] vcount_p0;
  logic       hsync_p0;
  logic       vsync_p0;
  logic       active_p0;
  logic       line_start_p0;
  logic       frame_start_p0;

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;

  // Next-state counts; every registered output is decoded from these so the
  // flags line up with the counts on the same cycle.
  always_comb begin
    h_wrap = (hcount_p0 == H_LAST);
    v_wrap = (vcount_p0 == V_LAST);
    h_next = h_wrap ? 10'd0 : hcount_p0 + 10'd1;
    v_next = vcount_p0;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vcount_p0 + 10'd1;
    end
  end

  // ---- stage p0: counters, decoded levels and one-clk strobes ----
  // Advance one pixel per enable; strobes self-clear on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_p0      <= 10'd0;
      vcount_p0      <= 10'd0;
      hsync_p0       <= ~HS_POL;
      vsync_p0       <= ~VS_POL;
      active_p0      <= 1'b1;
      line_start_p0  <= 1'b0;
      frame_start_p0 <= 1'b0;
    end else begin
      line_start_p0  <= 1'b0;
      frame_start_p0 <= 1'b0;
      if (pix_en) begin
        hcount_p0      <= h_next;
        vcount_p0      <= v_next;
        hsync_p0       <= sync_level(h_next, H_SYNC_LO, H_SYNC_HI, HS_POL);
        vsync_p0       <= sync_level(v_next, V_SYNC_LO, V_SYNC_HI, VS_POL);
        active_p0      <= in_window(h_next, 11'd0, H_ACT_END) &&
                          in_window(v_next, 11'd0, V_ACT_END);
        line_start_p0  <= h_wrap;
        frame_start_p0 <= h_wrap && v_wrap;
      end
    end
  end

  assign hcount      = hcount_p0;
  assign vcount      = vcount_p0;
  assign hsync       = hsync_p0;
  assign vsync       = vsync_p0;
  assign active      = active_p0;
  assign line_start  = line_start_p0;
  assign frame_start = frame_start_p0;

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_cnt_p0;

  // Count frames on the same edge that raises frame_start; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_p0 <= 16'd0;
    end else if (pix_en && h_wrap && v_wrap) begin
      frame_cnt_p0 <= frame_cnt_p0 + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 640x480 instance and a shrunken
// instance (31x15 totals, positive hsync) share clk/rst/pix_en. Each cycle
// both are compared against a position model: the number of enabled edges
// since reset, reduced modulo the frame size.
module tb_vga_timing_gen;

  // Shrunken geometry so whole frames fit in a short run.
  localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 5;
  localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
  localparam int D_FRAME = 800 * 525;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic [9:0] hc_d, vc_d, hc_s, vc_s;
  logic hs_d, vs_d, ac_d, ls_d, fs_d;
  logic hs_s, vs_s, ac_s, ls_s, fs_s;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] fc_d, fc_s;
`endif

  int tests = 0;
  int fails = 0;
  int n_d = 0;       // enabled edges since reset, default instance
  int n_s = 0;       // enabled edges since reset, small instance
  bit last_en = 1'b0;
  int fc_base_s = 0; // frame-count offset after preloading the small counter
  int cyc = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hc_d), .vcount(vc_d), .hsync(hs_d), .vsync(vs_d),
    .active(ac_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
    .active(ac_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_s)
`endif
  );

  // Expected {hcount, vcount, hsync, vsync, active, line_start, frame_start}
  // after n enabled edges; le says whether the most recent edge was enabled.
  function automatic logic [24:0] expect_vec(input int n, input bit le,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input bit hp, input bit vp);
    int ht, vt, pos, h, v;
    bit hsy, vsy, act, ls, fs;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    pos = n % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    hsy = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    vsy = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    act = (h < ha) && (v < va);
    ls  = le && (h == 0);
    fs  = ls && (v == 0);
    return {10'(h), 10'(v), hsy, vsy, act, ls, fs};
  endfunction

  task automatic check_all(input string tag);
    logic [24:0] exp_d, exp_s, obs_d, obs_s;
    exp_d = expect_vec(n_d, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    exp_s = expect_vec(n_s, last_en, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b0);
    obs_d = {hc_d, vc_d, hs_d, vs_d, ac_d, ls_d, fs_d};
    obs_s = {hc_s, vc_s, hs_s, vs_s, ac_s, ls_s, fs_s};
    tests++;
    assert (obs_d === exp_d) else begin
      fails++;
      $error("FAIL %s default cyc=%0d got h=%0d v=%0d hs/vs/act/ls/fs=%b want h=%0d v=%0d hs/vs/act/ls/fs=%b",
             tag, cyc, obs_d[24:15], obs_d[14:5], obs_d[4:0], exp_d[24:15], exp_d[14:5], exp_d[4:0]);
    end
    tests++;
    assert (obs_s === exp_s) else begin
      fails++;
      $error("FAIL %s small cyc=%0d got h=%0d v=%0d hs/vs/act/ls/fs=%b want h=%0d v=%0d hs/vs/act/ls/fs=%b",
             tag, cyc, obs_s[24:15], obs_s[14:5], obs_s[4:0], exp_s[24:15], exp_s[14:5], exp_s[4:0]);
    end
`ifdef VGA_FRAME_COUNTER_EN
    tests++;
    assert (fc_d === 16'(n_d / D_FRAME)) else begin
      fails++;
      $error("FAIL %s frame_cnt_default got %0d want %0d", tag, fc_d, 16'(n_d / D_FRAME));
    end
    tests++;
    assert (fc_s === 16'(fc_base_s + n_s / S_FRAME)) else begin
      fails++;
      $error("FAIL %s frame_cnt_small got %0d want %0d", tag, fc_s, 16'(fc_base_s + n_s / S_FRAME));
    end
`endif
  endtask

  task automatic model_reset();
    n_d = 0;
    n_s = 0;
    last_en = 1'b0;
    fc_base_s = 0;
  endtask

  // Drive pix_en from the falling edge, clock once, update model, check.
  task automatic step(input bit en, input string tag);
    pix_en = en;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      last_en = en;
      if (en) begin
        n_d++;
        n_s++;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int last_ls;
    int periods;

    // Power-on reset held over a few edges.
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1'b1, "reset_hold");
    rst = 1'b0;

    // Continuous enable: two full default lines plus several small frames.
    for (int i = 0; i < 1700; i++) step(1'b1, "cont");

    // Divided enable, one pulse in four clocks; default line period is 3200.
    last_ls = -1;
    periods = 0;
    for (int i = 0; i < 8000; i++) begin
      step((i % 4) == 0, "div4");
      if (ls_d) begin
        if (last_ls >= 0) begin
          periods++;
          tests++;
          assert (cyc - last_ls == 3200) else begin
            fails++;
            $error("FAIL line_period got %0d want %0d", cyc - last_ls, 3200);
          end
        end
        last_ls = cyc;
      end
    end
    tests++;
    assert (periods >= 1) else begin
      fails++;
      $error("FAIL line_period_seen got %0d want %0d", periods, 1);
    end

    // Random enable pattern.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 2) == 0, "rand");

    // Asynchronous reset mid-frame: outputs return with no clock edge.
    for (int i = 0; i < 37; i++) step(1'b1, "pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    tests++;
    assert ({hc_d, vc_d, hs_d, vs_d, ac_d, ls_d, fs_d} === {10'd0, 10'd0, 5'b11100}) else begin
      fails++;
      $error("FAIL async_rst_const got h=%0d v=%0d flags=%b want 0 0 11100",
             hc_d, vc_d, {hs_d, vs_d, ac_d, ls_d, fs_d});
    end
    @(negedge clk);
    step(1'b1, "rst_held");
    rst = 1'b0;
    step(1'b1, "first_after_rst");
    tests++;
    assert ({hc_s, vc_s, fs_s, ls_s} === {10'd1, 10'd0, 2'b00}) else begin
      fails++;
      $error("FAIL first_after_rst got h=%0d v=%0d fs=%b ls=%b want 1 0 0 0", hc_s, vc_s, fs_s, ls_s);
    end

    // Idle cycles: everything holds, strobes low.
    for (int i = 0; i < 20; i++) step(1'b0, "idle");

`ifdef VGA_FRAME_COUNTER_EN
    // Preload the small frame counter near its top and cross a frame edge.
    force dut_s.frame_cnt_p0 = 16'hFFFF;
    #1;
    release dut_s.frame_cnt_p0;
    fc_base_s = 65535 - n_s / S_FRAME;
    check_all("fc_preload");
    for (int i = 0; i < S_FRAME + 5; i++) step(1'b1, "fc_wrap");
    tests++;
    assert (fc_s === 16'd0) else begin
      fails++;
      $error("FAIL fc_wrap_final got %0d want %0d", fc_s, 0);
    end
`endif

    for (int i = 0; i < 2 * S_FRAME; i++) step(1'b1, "tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
